// File: rtl/pulse_burst_pkg.sv
// Shared state encoding and parameter defaults for the pulse burst counter.
package pulse_burst_pkg;

    localparam int CNT_W_DEF       = 4;
    localparam int IDLE_CYCLES_DEF = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BURST  = 2'b01,
        REPORT = 2'b10
    } state_e;

endpackage

// File: rtl/pulse_sync_edge.sv
// Optional input synchronizer plus rising-edge detector.
// Build switch PULSE_BURST_SYNC_EN inserts a SYNC_STAGES-deep flop chain ahead of the detector.
module pulse_sync_edge
    import pulse_burst_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic signal,
    output logic edge_o
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..3");
    end

    logic sig_s;
    logic prev_q;

`ifdef PULSE_BURST_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
    end

    assign sig_s = sync_q[SYNC_STAGES-1];
`else
    // Input must already be synchronous to clock in this build.
    assign sig_s = signal;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) prev_q <= 1'b0;
        else          prev_q <= sig_s;
    end

    assign edge_o = sig_s & ~prev_q;

endmodule

// File: rtl/pulse_burst_counter.sv
// Groups rising edges of a pulse train into bursts split by idle gaps and
// reports each burst's count over valid/ready. See pulse_sync_edge for PULSE_BURST_SYNC_EN.
module pulse_burst_counter
    import pulse_burst_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             signal,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overflow,
    output logic             drop
);

    if (IDLE_CYCLES < 2 || IDLE_CYCLES > 255) begin : g_bad_idle
        $error("IDLE_CYCLES must be 2..255");
    end

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       IDLE_LAST = 8'(IDLE_CYCLES - 1);

    logic edge_s;

    pulse_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clock  (clock),
        .reset_n(reset_n),
        .signal (signal),
        .edge_o (edge_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       idle_q, idle_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic             oflow_q, oflow_d;
    logic             valid_q, valid_d;
    logic             drop_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idle_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
            oflow_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            oflow_q <= oflow_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        ovf_d   = ovf_q;
        out_d   = out_q;
        oflow_d = oflow_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_s) begin
                    cnt_d   = CNT_ONE;
                    idle_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (edge_s) begin
                    idle_d = '0;
                    if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                  cnt_d = cnt_q + CNT_ONE;
                end else if (idle_q == IDLE_LAST) begin
                    // Snapshot into dedicated output flops so the report stays frozen.
                    idle_d  = '0;
                    out_d   = cnt_q;
                    oflow_d = ovf_q;
                    valid_d = 1'b1;
                    state_d = REPORT;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
            REPORT: begin
                if (valid_q && count_ready) begin
                    valid_d = 1'b0;
                    if (edge_s) begin
                        cnt_d   = CNT_ONE;
                        idle_d  = '0;
                        ovf_d   = 1'b0;
                        state_d = BURST;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (edge_s) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign count_out   = out_q;
    assign overflow    = oflow_q;
    assign count_valid = valid_q;
    assign drop        = drop_d;

endmodule
